// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizer plus stability-qualified debouncer with rise/fall pulses
// Raw din is synchronized, then a new level must hold STABLE_COUNT+1 samples before it is accepted.
module debounce_sync #(
   parameter int SYNC_STAGES  = 2,
   parameter int STABLE_COUNT = 50000,
   parameter int CNT_WIDTH    = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic data,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE_LOW   = 2'b00,
      CHECK_HIGH = 2'b01,
      IDLE_HIGH  = 2'b10,
      CHECK_LOW  = 2'b11
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "debounce_sync: SYNC_STAGES must be >= 2");
   end
   if (STABLE_COUNT < 2) begin : g_bad_count
      $fatal(1, "debounce_sync: STABLE_COUNT must be >= 2");
   end
   if ((64'd1 << CNT_WIDTH) <= 64'(STABLE_COUNT - 1)) begin : g_bad_width
      $fatal(1, "debounce_sync: CNT_WIDTH too small for STABLE_COUNT");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state;
   logic [CNT_WIDTH-1:0]   cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // A disagreeing sample during CHECK aborts back to the old level with cnt cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE_LOW;
         cnt   <= '0;
         data  <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            IDLE_LOW: begin
               if (s) begin
                  state <= CHECK_HIGH;
                  cnt   <= '0;
               end
            end
            CHECK_HIGH: begin
               if (!s) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE_HIGH;
                  data  <= 1'b1;
                  rise  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE_HIGH: begin
               if (!s) begin
                  state <= CHECK_LOW;
                  cnt   <= '0;
               end
            end
            CHECK_LOW: begin
               if (s) begin
                  state <= IDLE_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE_LOW;
                  data  <= 1'b0;
                  fall  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE_LOW;
               data  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign busy = (state == CHECK_HIGH) || (state == CHECK_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - randomized self-checking bench for debounce_sync
// Reference model: s is din delayed SYNC_STAGES edges; data flips once STABLE_COUNT+1 trailing samples disagree.
module tb_debounce_sync;

   localparam int SS = 2;
   localparam int SC = 4;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic din = 1'b0;
   logic data, rise, fall, busy;

   int checks = 0;
   int errors = 0;

   bit m_data, m_rise, m_fall, m_busy;
   bit din_q[$];
   bit s_q[$];

   debounce_sync #(
      .SYNC_STAGES (SS),
      .STABLE_COUNT(SC),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .din (din),
      .data(data),
      .rise(rise),
      .fall(fall),
      .busy(busy)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      din_q.delete();
      s_q.delete();
      m_data = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_busy = 1'b0;
   endtask

   task automatic model_step();
      bit s;
      int run;
      din_q.push_back(din);
      s = (din_q.size() > SS) ? din_q[din_q.size() - 1 - SS] : 1'b0;
      s_q.push_back(s);
      m_rise = 1'b0;
      m_fall = 1'b0;
      run = 0;
      for (int i = s_q.size() - 1; i >= 0; i--) begin
         if (s_q[i] == m_data) break;
         run++;
      end
      if (run >= SC + 1) begin
         m_data = !m_data;
         m_rise = m_data;
         m_fall = !m_data;
         s_q.delete();
         run = 0;
      end
      m_busy = (run > 0);
   endtask

   task automatic compare_outputs();
      check("data", {15'd0, data}, {15'd0, m_data});
      check("rise", {15'd0, rise}, {15'd0, m_rise});
      check("fall", {15'd0, fall}, {15'd0, m_fall});
      check("busy", {15'd0, busy}, {15'd0, m_busy});
   endtask

   // Drive din for one edge, advance the model on that edge, compare on the falling edge.
   task automatic cycle(input bit d);
      din = d;
      @(posedge clk);
      if (rst) model_step();
      else     model_reset();
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic measure(input bit d, input bit want_rise, output int lat, output int other);
      lat   = -1;
      other = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle(d);
         if (want_rise ? fall : rise) other++;
         if (want_rise ? rise : fall) begin
            lat = i;
            break;
         end
      end
   endtask

   // Async reset asserted between edges, checked before any further clock edge.
   task automatic reset_pulse(input int hold);
      #3 rst = 1'b0;
      #1;
      model_reset();
      check("async_rst_data", {15'd0, data}, 16'd0);
      check("async_rst_busy", {15'd0, busy}, 16'd0);
      check("async_rst_pulse", {14'd0, rise, fall}, 16'd0);
      for (int i = 0; i < hold; i++) cycle(din);
      rst = 1'b1;
   endtask

   initial begin
      int lat, other, pulses;
      bit d0, d;
      int runlen;

      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("reset_data", {15'd0, data}, 16'd0);
      check("reset_pulses", {14'd0, rise, fall}, 16'd0);
      check("reset_busy", {15'd0, busy}, 16'd0);
      rst = 1'b1;

      // clean rise after reset
      measure(1'b1, 1'b1, lat, other);
      check("rise_latency", 16'(lat), 16'd7);
      check("rise_no_fall", 16'(other), 16'd0);
      cycle(1'b1);
      check("rise_one_cycle", {15'd0, rise}, 16'd0);
      for (int i = 0; i < 4; i++) cycle(1'b1);

      // short low glitch while high
      pulses = 0;
      cycle(1'b0);
      cycle(1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1);
         if (fall) pulses++;
      end
      check("glitch_no_fall", 16'(pulses), 16'd0);
      check("glitch_data_held", {15'd0, data}, 16'd1);

      // clean fall
      measure(1'b0, 1'b0, lat, other);
      check("fall_latency", 16'(lat), 16'd7);
      check("fall_no_rise", 16'(other), 16'd0);
      cycle(1'b0);
      check("fall_one_cycle", {15'd0, fall}, 16'd0);
      for (int i = 0; i < 4; i++) cycle(1'b0);

      // reset mid-CHECK_HIGH, then full latency again
      for (int i = 0; i < 4; i++) cycle(1'b1);
      check("midcheck_busy", {15'd0, busy}, 16'd1);
      reset_pulse(2);
      measure(1'b1, 1'b1, lat, other);
      check("rise_after_rst", 16'(lat), 16'd7);

      // toggling every 3 cycles never qualifies
      d0 = data;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(((i / 3) % 2) == 0 ? 1'b0 : 1'b1);
         if (rise || fall) pulses++;
      end
      check("toggle_no_pulse", 16'(pulses), 16'd0);
      check("toggle_data", {15'd0, data}, {15'd0, d0});

      // random runs of varying length with occasional async resets
      d = 1'b0;
      for (int n = 0; n < 400; n++) begin
         d = ~d;
         runlen = $urandom_range(1, 9);
         for (int i = 0; i < runlen; i++) cycle(d);
         if ($urandom_range(0, 39) == 0) reset_pulse($urandom_range(1, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
